// File: rtl/avs_frame_deserializer.sv
// AVS frame deserializer: recovers the three-slot TDM serial stream (vectorx, vectory,
// pressure) and presents one signed parallel triplet per frame with a valid/ready handshake.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   bit_en, sdata, fsync     serial bit strobe, data bit, frame sync (first bit of a frame)
//   vectorx/vectory/pressure signed slot 0/1/2 samples (held while valid & !ready)
//   sample_valid, sample_ready  triplet handshake
//   sync_err                 one-cycle pulse: fsync arrived mid-frame
//   overrun                  one-cycle pulse: pending triplet overwritten by a newer one
//   frame_count              completed frames, wraps silently
module avs_frame_deserializer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SLOT_BITS = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        bit_en,
    input  logic                        sdata,
    input  logic                        fsync,
    output logic signed [WIDTH-1:0]     vectorx,
    output logic signed [WIDTH-1:0]     vectory,
    output logic signed [WIDTH-1:0]     pressure,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic                        sync_err,
    output logic                        overrun,
    output logic [CNT_WIDTH-1:0]        frame_count
);

    localparam int unsigned FrameBits = 3 * SLOT_BITS;
    localparam int unsigned IdxW      = $clog2(FrameBits);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameBits - 1);

    typedef enum logic [1:0] {StHunt, StCapture, StDone, StWait} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]      sx_q, sx_d, sy_q, sy_d, sp_q, sp_d;
    logic [WIDTH-1:0]      vx_q, vx_d, vy_q, vy_d, vp_q, vp_d;
    logic                  valid_q, valid_d;
    logic                  sync_err_q, sync_err_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // FSM control strobes
    logic start_frame;  // this bit becomes the vectorx MSB of a new frame
    logic take_bit;     // ordinary in-frame bit
    logic mid_sync;     // fsync while a frame is partially captured
    logic load_out;

    logic [1:0]      slot;
    logic [IdxW-1:0] pos;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StHunt, StWait: if (bit_en && fsync) state_d = StCapture;
            StCapture:      if (bit_en && !fsync && idx_q == LastIdx) state_d = StDone;
            StDone:         state_d = StWait;
            default:        state_d = StHunt;
        endcase
    end

    // FSM outputs
    always_comb begin
        start_frame = bit_en && fsync;
        take_bit    = 1'b0;
        mid_sync    = 1'b0;
        load_out    = 1'b0;
        case (state_q)
            StHunt, StWait: ;
            StCapture: begin
                take_bit = bit_en && !fsync;
                mid_sync = bit_en && fsync && (idx_q != '0);
            end
            StDone: begin
                start_frame = 1'b0;
                load_out    = 1'b1;
            end
            default: start_frame = 1'b0;
        endcase
    end

    // Split the frame bit index into slot number and position within the slot
    always_comb begin
        if (idx_q < IdxW'(SLOT_BITS)) begin
            slot = 2'd0;
            pos  = idx_q;
        end else if (idx_q < IdxW'(2 * SLOT_BITS)) begin
            slot = 2'd1;
            pos  = idx_q - IdxW'(SLOT_BITS);
        end else begin
            slot = 2'd2;
            pos  = idx_q - IdxW'(2 * SLOT_BITS);
        end
    end

    // Datapath next state
    always_comb begin
        idx_d      = idx_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        sp_d       = sp_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        vp_d       = vp_q;
        valid_d    = valid_q;
        count_d    = count_q;
        sync_err_d = mid_sync;
        overrun_d  = load_out && valid_q && !sample_ready;

        if (start_frame) begin
            // Any partial frame is dropped; the sync bit is the new vectorx MSB
            sx_d  = {{(WIDTH-1){1'b0}}, sdata};
            sy_d  = '0;
            sp_d  = '0;
            idx_d = IdxW'(1);
        end else if (take_bit) begin
            // Trailing filler bits of a slot are counted but not stored
            if (32'(pos) < WIDTH) begin
                case (slot)
                    2'd0:    sx_d = {sx_q[WIDTH-2:0], sdata};
                    2'd1:    sy_d = {sy_q[WIDTH-2:0], sdata};
                    default: sp_d = {sp_q[WIDTH-2:0], sdata};
                endcase
            end
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end

        if (valid_q && sample_ready) valid_d = 1'b0;
        if (load_out) begin
            vx_d    = sx_q;
            vy_d    = sy_q;
            vp_d    = sp_q;
            valid_d = 1'b1;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            sp_q       <= '0;
            vx_q       <= '0;
            vy_q       <= '0;
            vp_q       <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            idx_q      <= idx_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            sp_q       <= sp_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            vp_q       <= vp_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    assign vectorx      = vx_q;
    assign vectory      = vy_q;
    assign pressure     = vp_q;
    assign sample_valid = valid_q;
    assign sync_err     = sync_err_q;
    assign overrun      = overrun_q;
    assign frame_count  = count_q;

endmodule

// File: tb/tb_avs_frame_deserializer.sv
// Bench for avs_frame_deserializer: table-driven frames, hand-written overrun/handshake
// sequences, randomized frames against a frame-level reference, and counter wrap on a
// second instance with 24-bit slots and a 2-bit frame counter.
module tb_avs_frame_deserializer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic be0, sd0, fs0, be1, sd1, fs1, ready;
    logic signed [15:0] x0, y0, p0, x1, y1, p1;
    logic v0, v1, se0, se1, ov0, ov1;
    logic [15:0] fc0;
    logic [1:0]  fc1;

    avs_frame_deserializer #(.WIDTH(16), .SLOT_BITS(16), .CNT_WIDTH(16)) u_dut0 (
        .clock(clock), .reset(reset), .bit_en(be0), .sdata(sd0), .fsync(fs0),
        .vectorx(x0), .vectory(y0), .pressure(p0), .sample_valid(v0),
        .sample_ready(ready), .sync_err(se0), .overrun(ov0), .frame_count(fc0)
    );

    avs_frame_deserializer #(.WIDTH(16), .SLOT_BITS(24), .CNT_WIDTH(2)) u_dut1 (
        .clock(clock), .reset(reset), .bit_en(be1), .sdata(sd1), .fsync(fs1),
        .vectorx(x1), .vectory(y1), .pressure(p1), .sample_valid(v1),
        .sample_ready(ready), .sync_err(se1), .overrun(ov1), .frame_count(fc1)
    );

    // Observed instance select
    logic sel;
    logic signed [15:0] ox, oy, op;
    logic ovld, ose, oov;
    int ofc;
    always_comb begin
        if (sel) begin
            ox = x1; oy = y1; op = p1; ovld = v1; ose = se1; oov = ov1; ofc = int'(fc1);
        end else begin
            ox = x0; oy = y0; op = p0; ovld = v0; ose = se0; oov = ov0; ofc = int'(fc0);
        end
    end

    typedef struct {int x; int y; int p;} trip_t;
    trip_t acc_q[$];
    int se_cnt, ov_cnt;

    // Record every accepted triplet and every status pulse
    always @(negedge clock) begin
        if (!reset) begin
            if (ovld && ready) acc_q.push_back('{int'(ox), int'(oy), int'(op)});
            if (ose) se_cnt++;
            if (oov) ov_cnt++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        se_cnt = 0;
        ov_cnt = 0;
        acc_q.delete();
    endtask

    // Bit idx of a frame: slot = idx / slot_bits, first 16 bits of a slot are the word MSB-first,
    // remaining bits come from the filler pattern.
    function automatic logic frame_bit(input int slot_bits, input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] p, input logic [7:0] filler, input int idx);
        int slot;
        int pos;
        logic [15:0] w;
        slot = idx / slot_bits;
        pos  = idx % slot_bits;
        w = (slot == 0) ? x : (slot == 1) ? y : p;
        if (pos < 16) return w[15-pos];
        return filler[(pos-16)%8];
    endfunction

    function automatic int frame_len(input logic s);
        return s ? 72 : 48;
    endfunction

    // Send the first n bits of a frame; returns #2 after the edge that took the last bit
    task automatic send_bits(input logic s, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] p, input logic [7:0] filler, input int n,
                             input int gap);
        int sb;
        logic b;
        sb = s ? 24 : 16;
        for (int i = 0; i < n; i++) begin
            b = frame_bit(sb, x, y, p, filler, i);
            if (s) begin
                be1 = 1'b1; fs1 = (i == 0); sd1 = b;
            end else begin
                be0 = 1'b1; fs0 = (i == 0); sd0 = b;
            end
            @(posedge clock);
            #2;
            if (gap > 0 || i == n - 1) begin
                be0 = 1'b0; be1 = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
            end
            if (i != n - 1) idle(gap);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x"}, int'(ox), 0);
        check({tag, "_y"}, int'(oy), 0);
        check({tag, "_p"}, int'(op), 0);
        check({tag, "_valid"}, int'(ovld), 0);
        check({tag, "_syncerr"}, int'(ose), 0);
        check({tag, "_overrun"}, int'(oov), 0);
        check({tag, "_count"}, ofc, 0);
    endtask

    typedef struct {
        logic        sel;
        int          partial;  // bits of an aborted frame sent first
        int          rst_at;   // reset after this many bits of the frame, -1 = none
        logic [15:0] x, y, p;
        logic [7:0]  filler;
        int          gap;
        int          ex, ey, ep;
    } vec_t;

    vec_t vecs[4];

    initial begin
        trip_t t;
        int model_cnt;
        int exp_se;
        logic [15:0] rx, ry, rp;
        logic [7:0] rf;

        reset = 1'b1;
        be0 = 0; sd0 = 0; fs0 = 0; be1 = 0; sd1 = 0; fs1 = 0;
        ready = 1'b0;
        sel = 1'b0;
        se_cnt = 0;
        ov_cnt = 0;
        idle(2);
        reset = 1'b0;

        vecs[0] = '{1'b0, 0, -1, 16'h7FFF, 16'h8000, 16'h0123, 8'h00, 3, 32767, -32768, 291};
        vecs[1] = '{1'b0, 20, -1, 16'hFFFF, 16'h0002, 16'hFFFD, 8'h00, 1, -1, 2, -3};
        vecs[2] = '{1'b0, 0, 30, 16'd100, 16'd200, 16'd300, 8'h00, 0, 100, 200, 300};
        vecs[3] = '{1'b1, 0, -1, 16'h1234, 16'hABCD, 16'h0001, 8'hA5, 2, 4660, -21555, 1};

        // Table-driven frames
        for (int r = 0; r < 4; r++) begin
            sel = vecs[r].sel;
            ready = 1'b1;
            do_reset();
            check_zero($sformatf("row%0d_rst", r));
            clear_obs();
            if (vecs[r].rst_at >= 0) begin
                send_bits(sel, 16'h5A5A, 16'hA5A5, 16'h0F0F, 8'h00, frame_len(sel), 0);
                idle(3);
                check($sformatf("row%0d_pre_count", r), ofc, 1);
                check($sformatf("row%0d_pre_x", r), int'(ox), 16'h5A5A);
                acc_q.delete();
                send_bits(sel, vecs[r].x, vecs[r].y, vecs[r].p, vecs[r].filler,
                          vecs[r].rst_at, vecs[r].gap);
                reset = 1'b1;
                idle(1);
                check_zero($sformatf("row%0d_midrst", r));
                reset = 1'b0;
                idle(1);
                check_zero($sformatf("row%0d_postrst", r));
            end
            if (vecs[r].partial > 0)
                send_bits(sel, 16'h3C3C, 16'hC3C3, 16'h1111, vecs[r].filler,
                          vecs[r].partial, vecs[r].gap);
            send_bits(sel, vecs[r].x, vecs[r].y, vecs[r].p, vecs[r].filler,
                      frame_len(sel), vecs[r].gap);
            check($sformatf("row%0d_done_valid", r), int'(ovld), 0);
            idle(1);
            check($sformatf("row%0d_valid", r), int'(ovld), 1);
            check($sformatf("row%0d_x", r), int'(ox), vecs[r].ex);
            check($sformatf("row%0d_y", r), int'(oy), vecs[r].ey);
            check($sformatf("row%0d_p", r), int'(op), vecs[r].ep);
            check($sformatf("row%0d_count", r), ofc, 1);
            idle(1);
            check($sformatf("row%0d_valid_clr", r), int'(ovld), 0);
            check($sformatf("row%0d_syncerr_n", r), se_cnt, (vecs[r].partial > 0) ? 1 : 0);
            check($sformatf("row%0d_overrun_n", r), ov_cnt, 0);
            check($sformatf("row%0d_accepts", r), acc_q.size(), 1);
            if (acc_q.size() > 0)
                check($sformatf("row%0d_acc_x", r), acc_q[0].x, vecs[r].ex);
        end

        // Back-to-back frames with no consumer: overrun
        sel = 1'b0;
        ready = 1'b0;
        do_reset();
        clear_obs();
        send_bits(1'b0, 16'd1, 16'd2, 16'd3, 8'h00, 48, 1);
        idle(2);
        check("ovr_f1_valid", int'(ovld), 1);
        check("ovr_f1_x", int'(ox), 1);
        check("ovr_f1_p", int'(op), 3);
        check("ovr_f1_overrun_n", ov_cnt, 0);
        send_bits(1'b0, 16'd4, 16'd5, 16'd6, 8'h00, 48, 0);
        idle(2);
        check("ovr_f2_x", int'(ox), 4);
        check("ovr_f2_y", int'(oy), 5);
        check("ovr_f2_p", int'(op), 6);
        check("ovr_f2_valid", int'(ovld), 1);
        check("ovr_f2_overrun_n", ov_cnt, 1);
        check("ovr_f2_count", ofc, 2);
        idle(3);
        check("ovr_hold_x", int'(ox), 4);
        check("ovr_hold_valid", int'(ovld), 1);
        check("ovr_hold_overrun_n", ov_cnt, 1);
        check("ovr_hold_accepts", acc_q.size(), 0);

        // Accept coinciding with DONE: no overrun, new triplet loads, valid stays
        send_bits(1'b0, 16'd7, 16'd8, 16'd9, 8'h00, 48, 0);
        ready = 1'b1;
        idle(1);
        check("acc_done_x", int'(ox), 7);
        check("acc_done_p", int'(op), 9);
        check("acc_done_valid", int'(ovld), 1);
        check("acc_done_overrun_n", ov_cnt, 1);
        check("acc_done_accepts", acc_q.size(), 1);
        if (acc_q.size() > 0) check("acc_done_first", acc_q[0].x, 4);
        idle(1);
        check("acc_after_valid", int'(ovld), 0);
        check("acc_after_accepts", acc_q.size(), 2);
        if (acc_q.size() > 1) check("acc_after_second", acc_q[1].y, 8);
        check("acc_after_count", ofc, 3);

        // Randomized frames with occasional aborted frames, against a frame-level model
        sel = 1'b0;
        ready = 1'b1;
        do_reset();
        clear_obs();
        model_cnt = 0;
        exp_se = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_bits(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 8'h00,
                          int'($urandom_range(1, 47)), int'($urandom_range(0, 2)));
                exp_se++;
            end
            rx = 16'($urandom);
            ry = 16'($urandom);
            rp = 16'($urandom);
            send_bits(1'b0, rx, ry, rp, 8'h00, 48, int'($urandom_range(0, 2)));
            model_cnt = (model_cnt + 1) % 65536;
            idle(int'($urandom_range(2, 4)));
            check("rnd_accepts", acc_q.size(), 1);
            if (acc_q.size() > 0) begin
                t = acc_q.pop_front();
                check("rnd_x", t.x, int'($signed(rx)));
                check("rnd_y", t.y, int'($signed(ry)));
                check("rnd_p", t.p, int'($signed(rp)));
            end
            check("rnd_count", ofc, model_cnt);
        end
        check("rnd_syncerr_n", se_cnt, exp_se);
        check("rnd_overrun_n", ov_cnt, 0);

        // 24-bit slots with random filler; 2-bit counter wraps after four frames
        sel = 1'b1;
        ready = 1'b1;
        do_reset();
        clear_obs();
        for (int k = 1; k <= 5; k++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rp = 16'($urandom);
            rf = 8'($urandom_range(1, 255));
            send_bits(1'b1, rx, ry, rp, rf, 72, int'($urandom_range(0, 1)));
            idle(3);
            check("wrap_count", ofc, k % 4);
            check("wrap_accepts", acc_q.size(), 1);
            if (acc_q.size() > 0) begin
                t = acc_q.pop_front();
                check("wrap_x", t.x, int'($signed(rx)));
                check("wrap_p", t.p, int'($signed(rp)));
            end
        end
        check("wrap_syncerr_n", se_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
